// File: rtl/run_length_logger.sv
// Run-length logger: times each high run of the detector output, counts runs, and queues the lengths in a FWFT FIFO.
// Optional sticky drop flag on port `overflow` is built only when RLL_OVERFLOW_EN is defined.
module run_length_logger #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             det_in,
    input  logic             clear,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [LEN_W-1:0] rd_len,
    output logic [CNT_W-1:0] evt_count,
    output logic             fifo_full,
`ifdef RLL_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             active
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX   = '1;
    localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [LEN_W-1:0] r_len_cnt, w_len_nxt;
    logic             w_push, w_pop, w_wr_en;
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_evt_count;
    logic [LEN_W-1:0] r_mem [DEPTH];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_cnt;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (det_in) begin
                    w_state_nxt = RUN;
                    w_len_nxt   = LEN_W'(1);
                end
            end
            RUN: begin
                if (det_in) begin
                    if (r_len_cnt != LEN_MAX) w_len_nxt = r_len_cnt + 1'b1;
                end else begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                    w_len_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_len_nxt   = '0;
            end
        endcase
    end

    // When full, a same-edge pop frees the slot the push lands in, so order is kept.
    assign w_pop   = rd_valid && rd_ready;
    assign w_wr_en = w_push && (!fifo_full || w_pop);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_len_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_evt_count <= '0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_len_cnt   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_evt_count <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_len_cnt <= w_len_nxt;
            if (w_push)  r_evt_count <= r_evt_count + 1'b1;
            if (w_wr_en) r_wr_ptr    <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr    <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only visible through rd_valid, which is.
    always_ff @(posedge clock) begin
        if (w_wr_en && !clear) r_mem[r_wr_ptr] <= r_len_cnt;
    end

`ifdef RLL_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                  r_overflow <= 1'b0;
        else if (clear)              r_overflow <= 1'b0;
        else if (w_push && !w_wr_en) r_overflow <= 1'b1;
    end

    assign overflow = r_overflow;
`endif

    assign rd_valid  = (r_count != '0);
    assign fifo_full = (r_count == COUNT_MAX);
    assign rd_len    = rd_valid ? r_mem[r_rd_ptr] : '0;
    assign evt_count = r_evt_count;
    assign active    = (r_state == RUN);

endmodule

// File: tb/tb_run_length_logger.sv
// Scoreboard bench for run_length_logger: stimulus queues expected lengths, a monitor checks every FIFO pop.
// Overflow checks are included when RLL_OVERFLOW_EN is defined.
module tb_run_length_logger;

    localparam int LEN_W = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             det_in = 1'b0;
    logic             clear = 1'b0;
    logic             rd_ready = 1'b0;
    logic             rd_valid;
    logic [LEN_W-1:0] rd_len;
    logic [CNT_W-1:0] evt_count;
    logic             fifo_full;
    logic             active;
`ifdef RLL_OVERFLOW_EN
    logic             overflow;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    run_length_logger #(.LEN_W(LEN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .det_in    (det_in),
        .clear     (clear),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_len    (rd_len),
        .evt_count (evt_count),
        .fifo_full (fifo_full),
`ifdef RLL_OVERFLOW_EN
        .overflow  (overflow),
`endif
        .active    (active)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_valid"},  rd_valid,  0);
        check({tag, "_rd_len"},    rd_len,    0);
        check({tag, "_evt_count"}, evt_count, 0);
        check({tag, "_fifo_full"}, fifo_full, 0);
        check({tag, "_active"},    active,    0);
`ifdef RLL_OVERFLOW_EN
        check({tag, "_overflow"},  overflow,  0);
`endif
    endtask

    // One sampled cycle: drive det_in, let the edge happen, return 1 time unit later.
    task automatic step(input logic d);
        det_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic run_of(input int n);
        repeat (n) step(1'b1);
        step(1'b0);
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) step(1'b0);
        rd_ready = 1'b0;
    endtask

    // Monitor: a pop happens on the next edge, so compare the head now against the scoreboard.
    always @(negedge clock) begin
        if (reset && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) check("unexpected_pop_rd_valid", rd_valid, 0);
            else check("head_rd_len", rd_len, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with det_in toggling.
        for (int i = 0; i < 4; i++) begin
            step(i[0]);
            check_all_zero("in_reset");
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check_all_zero("idle_after_reset");
        end

        // Single run of 5.
        step(1'b1);
        check("single_active_rise", active, 1);
        repeat (4) step(1'b1);
        exp_q.push_back(5);
        step(1'b0);
        check("single_rd_valid", rd_valid, 1);
        check("single_rd_len", rd_len, 5);
        check("single_evt_count", evt_count, 1);
        check("single_active_fall", active, 0);
        drain(1);
        check("single_drained", rd_valid, 0);

        // Saturating length counter.
        exp_q.push_back(255);
        run_of(300);
        check("sat_rd_len", rd_len, 255);
        check("sat_evt_count", evt_count, 2);
        drain(1);
        check("sat_drained", rd_valid, 0);

        // Fill past capacity with runs 1..5; the fifth is dropped.
        clear = 1'b1;
        step(1'b0);
        clear = 1'b0;
        check_all_zero("after_clear");
        for (int l = 1; l <= 4; l++) begin
            exp_q.push_back(l);
            run_of(l);
        end
        check("ovf_full_after4", fifo_full, 1);
        check("ovf_evt_after4", evt_count, 4);
        run_of(5);
        check("ovf_evt_after5", evt_count, 5);
        check("ovf_still_full", fifo_full, 1);
        check("ovf_head_kept", rd_len, 1);
`ifdef RLL_OVERFLOW_EN
        check("ovf_flag_set", overflow, 1);
`endif

        // Run of 7 ending on the same edge as a pop while full.
        repeat (7) step(1'b1);
        rd_ready = 1'b1;
        exp_q.push_back(7);
        step(1'b0);
        rd_ready = 1'b0;
        check("pushpop_full", fifo_full, 1);
        check("pushpop_evt", evt_count, 6);
        check("pushpop_head", rd_len, 2);
`ifdef RLL_OVERFLOW_EN
        check("pushpop_ovf_kept", overflow, 1);
`endif
        drain(4);
        check("pushpop_drained_valid", rd_valid, 0);
        check("pushpop_drained_full", fifo_full, 0);

        // Clear mid-run with det_in held high.
        clear = 1'b1;
        step(1'b0);
        clear = 1'b0;
        check_all_zero("clear2");
        repeat (3) step(1'b1);
        clear = 1'b1;
        step(1'b1);
        clear = 1'b0;
        check("clr_active_off", active, 0);
        check("clr_evt_zero", evt_count, 0);
        step(1'b1);
        check("clr_restart_active", active, 1);
        step(1'b1);
        exp_q.push_back(2);
        step(1'b0);
        check("clr_evt_count", evt_count, 1);
        check("clr_rd_len", rd_len, 2);
        drain(1);

        // Async reset mid-run.
        repeat (3) step(1'b1);
        reset = 1'b0;
        #1;
        check("rst_async_active", active, 0);
        check("rst_async_valid", rd_valid, 0);
        step(1'b1);
        reset = 1'b1;
        step(1'b1);
        check("rst_restart_active", active, 1);
        step(1'b1);
        exp_q.push_back(2);
        step(1'b0);
        check("rst_evt_count", evt_count, 1);
        check("rst_rd_len", rd_len, 2);
        drain(1);
        check("rst_drained", rd_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
